// File: rtl/decode_stage_reg.sv
// Registered MIPS decode stage: one instruction per accepted transfer, 1-cycle latency into the ID/EX bundle.
// Backpressure: the bundle holds while ex_ready=0; load-use hazards insert one bubble; HALT is sticky until flush/RST.
module decode_stage_reg #(
  parameter int PC_W      = 32,
  parameter bit EN_ATOMIC = 1'b1,
  parameter bit EN_HAZARD = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_npc,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            ex_valid,
  output logic [1:0]      ex_pcsrc,
  output logic [1:0]      ex_extop,
  output logic            ex_alusrc,
  output logic            ex_shamt_sel,
  output logic [3:0]      ex_aluop,
  output logic [1:0]      ex_wdat_sel,
  output logic [4:0]      ex_wsel,
  output logic            ex_rWEN,
  output logic            ex_dREN,
  output logic            ex_dWEN,
  output logic            ex_datomic,
  output logic            ex_bne,
  output logic            ex_halt,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [15:0]     ex_imm,
  output logic [4:0]      ex_shamt,
  output logic [PC_W-1:0] ex_npc,
  output logic            halted,
  output logic            illegal
);

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRL  = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_LL    = 6'h30;
  localparam logic [5:0] OP_SC    = 6'h38;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [0:0] {S_RUN, S_HALTED} state_t;
  state_t state, state_nxt;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign opcode = if_instr[31:26];
  assign rs     = if_instr[25:21];
  assign rt     = if_instr[20:16];
  assign rd     = if_instr[15:11];
  assign shamt  = if_instr[10:6];
  assign funct  = if_instr[5:0];
  assign imm    = if_instr[15:0];

  logic [1:0] d_pcsrc, d_extop, d_wdat_sel;
  logic       d_alusrc, d_shamt_sel;
  logic [3:0] d_aluop;
  logic [4:0] d_wsel;
  logic       d_rwen, d_dren, d_dwen, d_atomic, d_bne, d_halt, d_illegal;
  logic       uses_rs, uses_rt;

  always_comb begin
    d_pcsrc     = 2'd0;
    d_extop     = 2'd0;
    d_alusrc    = 1'b0;
    d_shamt_sel = 1'b0;
    d_aluop     = ALU_ADD;
    d_wdat_sel  = 2'd2;
    d_wsel      = rt;
    d_rwen      = 1'b0;
    d_dren      = 1'b0;
    d_dwen      = 1'b0;
    d_atomic    = 1'b0;
    d_bne       = 1'b0;
    d_halt      = 1'b0;
    d_illegal   = 1'b0;
    uses_rs     = 1'b1;
    uses_rt     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        d_wsel  = rd;
        d_rwen  = 1'b1;
        case (funct)
          FN_SLL: begin d_aluop = ALU_SLL; d_alusrc = 1'b1; d_shamt_sel = 1'b1; end
          FN_SRL: begin d_aluop = ALU_SRL; d_alusrc = 1'b1; d_shamt_sel = 1'b1; end
          FN_JR:  begin d_pcsrc = 2'd2; d_rwen = 1'b0; end
          FN_ADD, FN_ADDU: d_aluop = ALU_ADD;
          FN_SUB, FN_SUBU: d_aluop = ALU_SUB;
          FN_AND:  d_aluop = ALU_AND;
          FN_OR:   d_aluop = ALU_OR;
          FN_XOR:  d_aluop = ALU_XOR;
          FN_NOR:  d_aluop = ALU_NOR;
          FN_SLT:  d_aluop = ALU_SLT;
          FN_SLTU: d_aluop = ALU_SLTU;
          default: begin d_illegal = 1'b1; d_rwen = 1'b0; end
        endcase
      end
      OP_J:   begin uses_rs = 1'b0; d_pcsrc = 2'd1; end
      OP_JAL: begin
        uses_rs = 1'b0; d_pcsrc = 2'd1; d_wsel = 5'd31; d_wdat_sel = 2'd3; d_rwen = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        uses_rt = 1'b1; d_pcsrc = 2'd3; d_extop = 2'd1; d_aluop = ALU_SUB;
        d_bne   = (opcode == OP_BNE);
      end
      OP_ADDI, OP_ADDIU: begin d_alusrc = 1'b1; d_extop = 2'd1; d_rwen = 1'b1; end
      OP_SLTI:  begin d_alusrc = 1'b1; d_extop = 2'd1; d_aluop = ALU_SLT;  d_rwen = 1'b1; end
      OP_SLTIU: begin d_alusrc = 1'b1; d_extop = 2'd1; d_aluop = ALU_SLTU; d_rwen = 1'b1; end
      OP_ANDI:  begin d_alusrc = 1'b1; d_aluop = ALU_AND; d_rwen = 1'b1; end
      OP_ORI:   begin d_alusrc = 1'b1; d_aluop = ALU_OR;  d_rwen = 1'b1; end
      OP_XORI:  begin d_alusrc = 1'b1; d_aluop = ALU_XOR; d_rwen = 1'b1; end
      OP_LUI: begin
        uses_rs = 1'b0; d_extop = 2'd2; d_alusrc = 1'b1; d_wdat_sel = 2'd0; d_rwen = 1'b1;
      end
      OP_LW: begin
        d_alusrc = 1'b1; d_extop = 2'd1; d_wdat_sel = 2'd1; d_rwen = 1'b1; d_dren = 1'b1;
      end
      OP_SW: begin uses_rt = 1'b1; d_alusrc = 1'b1; d_extop = 2'd1; d_dwen = 1'b1; end
      OP_LL: begin
        if (EN_ATOMIC) begin
          d_alusrc = 1'b1; d_extop = 2'd1; d_wdat_sel = 2'd1;
          d_rwen   = 1'b1; d_dren  = 1'b1; d_atomic   = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_SC: begin
        uses_rt = 1'b1;
        // SC writes its success flag back to rt through the memory return path
        if (EN_ATOMIC) begin
          d_alusrc = 1'b1; d_extop = 2'd1; d_wdat_sel = 2'd1;
          d_rwen   = 1'b1; d_dwen  = 1'b1; d_atomic   = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_HALT: begin uses_rs = 1'b0; d_halt = 1'b1; end
      default: d_illegal = 1'b1;
    endcase
    if (d_wsel == 5'd0) d_rwen = 1'b0;
  end

  logic adv, hazard, accept;

  assign adv    = !ex_valid || ex_ready;
  assign hazard = EN_HAZARD && ex_valid && ex_dREN && ex_rWEN && (ex_wsel != 5'd0) &&
                  ((uses_rs && (ex_wsel == rs)) || (uses_rt && (ex_wsel == rt)));
  assign id_ready = (state == S_RUN) && adv && !hazard && !flush && !RST;
  assign accept   = if_valid && id_ready;
  assign halted   = (state == S_HALTED);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)                  state_nxt = S_RUN;
    else if (accept && d_halt)  state_nxt = S_HALTED;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid     <= 1'b0;
      ex_pcsrc     <= 2'd0;
      ex_extop     <= 2'd0;
      ex_alusrc    <= 1'b0;
      ex_shamt_sel <= 1'b0;
      ex_aluop     <= 4'd0;
      ex_wdat_sel  <= 2'd0;
      ex_wsel      <= 5'd0;
      ex_rWEN      <= 1'b0;
      ex_dREN      <= 1'b0;
      ex_dWEN      <= 1'b0;
      ex_datomic   <= 1'b0;
      ex_bne       <= 1'b0;
      ex_halt      <= 1'b0;
      ex_rs        <= 5'd0;
      ex_rt        <= 5'd0;
      ex_imm       <= 16'd0;
      ex_shamt     <= 5'd0;
      ex_npc       <= '0;
      illegal      <= 1'b0;
    end else begin
      illegal <= accept && d_illegal;
      if (accept) begin
        ex_valid     <= 1'b1;
        ex_pcsrc     <= d_pcsrc;
        ex_extop     <= d_extop;
        ex_alusrc    <= d_alusrc;
        ex_shamt_sel <= d_shamt_sel;
        ex_aluop     <= d_aluop;
        ex_wdat_sel  <= d_wdat_sel;
        ex_wsel      <= d_wsel;
        ex_rWEN      <= d_rwen;
        ex_dREN      <= d_dren;
        ex_dWEN      <= d_dwen;
        ex_datomic   <= d_atomic;
        ex_bne       <= d_bne;
        ex_halt      <= d_halt;
        ex_rs        <= rs;
        ex_rt        <= rt;
        ex_imm       <= imm;
        ex_shamt     <= shamt;
        ex_npc       <= if_npc;
      end else if (adv || flush) begin
        // bubble: side-effecting enables are dropped so a stale bundle can never act
        ex_valid   <= 1'b0;
        ex_rWEN    <= 1'b0;
        ex_dREN    <= 1'b0;
        ex_dWEN    <= 1'b0;
        ex_datomic <= 1'b0;
        ex_halt    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_reg.sv
// Scoreboard bench for decode_stage_reg: default instance plus a no-hazard, no-atomic instance.
module tb_decode_stage_reg;

  logic        CLK = 1'b0;
  logic        RST, if_valid, ex_ready, flush;
  logic [31:0] if_instr, if_npc;
  logic        id_ready, ex_valid, ex_alusrc, ex_shamt_sel;
  logic [1:0]  ex_pcsrc, ex_extop, ex_wdat_sel;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_wsel, ex_rs, ex_rt, ex_shamt;
  logic        ex_rWEN, ex_dREN, ex_dWEN, ex_datomic, ex_bne, ex_halt;
  logic [15:0] ex_imm;
  logic [31:0] ex_npc;
  logic        halted, illegal;

  logic        b_RST, b_if_valid, b_ex_ready, b_flush;
  logic [31:0] b_if_instr, b_if_npc;
  logic        b_id_ready, b_ex_valid, b_ex_alusrc, b_ex_shamt_sel;
  logic [1:0]  b_ex_pcsrc, b_ex_extop, b_ex_wdat_sel;
  logic [3:0]  b_ex_aluop;
  logic [4:0]  b_ex_wsel, b_ex_rs, b_ex_rt, b_ex_shamt;
  logic        b_ex_rWEN, b_ex_dREN, b_ex_dWEN, b_ex_datomic, b_ex_bne, b_ex_halt;
  logic [15:0] b_ex_imm;
  logic [31:0] b_ex_npc;
  logic        b_halted, b_illegal;

  always #5 CLK = ~CLK;

  decode_stage_reg dut (
    .CLK(CLK), .RST(RST), .if_valid(if_valid), .if_instr(if_instr), .if_npc(if_npc),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid),
    .ex_pcsrc(ex_pcsrc), .ex_extop(ex_extop), .ex_alusrc(ex_alusrc), .ex_shamt_sel(ex_shamt_sel),
    .ex_aluop(ex_aluop), .ex_wdat_sel(ex_wdat_sel), .ex_wsel(ex_wsel), .ex_rWEN(ex_rWEN),
    .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_datomic(ex_datomic), .ex_bne(ex_bne),
    .ex_halt(ex_halt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_imm(ex_imm), .ex_shamt(ex_shamt),
    .ex_npc(ex_npc), .halted(halted), .illegal(illegal)
  );

  decode_stage_reg #(.PC_W(32), .EN_ATOMIC(1'b0), .EN_HAZARD(1'b0)) dut_b (
    .CLK(CLK), .RST(b_RST), .if_valid(b_if_valid), .if_instr(b_if_instr), .if_npc(b_if_npc),
    .id_ready(b_id_ready), .ex_ready(b_ex_ready), .flush(b_flush), .ex_valid(b_ex_valid),
    .ex_pcsrc(b_ex_pcsrc), .ex_extop(b_ex_extop), .ex_alusrc(b_ex_alusrc),
    .ex_shamt_sel(b_ex_shamt_sel), .ex_aluop(b_ex_aluop), .ex_wdat_sel(b_ex_wdat_sel),
    .ex_wsel(b_ex_wsel), .ex_rWEN(b_ex_rWEN), .ex_dREN(b_ex_dREN), .ex_dWEN(b_ex_dWEN),
    .ex_datomic(b_ex_datomic), .ex_bne(b_ex_bne), .ex_halt(b_ex_halt), .ex_rs(b_ex_rs),
    .ex_rt(b_ex_rt), .ex_imm(b_ex_imm), .ex_shamt(b_ex_shamt), .ex_npc(b_ex_npc),
    .halted(b_halted), .illegal(b_illegal)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control vector built from explicit per-instruction field values
  function automatic logic [22:0] mk(int pc, int ext, int asrc, int sh, int op, int wd, int ws,
                                     int rw, int dr, int dw, int at, int bn, int ht);
    return {2'(pc), 2'(ext), 1'(asrc), 1'(sh), 4'(op), 2'(wd), 5'(ws),
            1'(rw), 1'(dr), 1'(dw), 1'(at), 1'(bn), 1'(ht)};
  endfunction

  function automatic logic [22:0] ctl_now();
    return {ex_pcsrc, ex_extop, ex_alusrc, ex_shamt_sel, ex_aluop, ex_wdat_sel, ex_wsel,
            ex_rWEN, ex_dREN, ex_dWEN, ex_datomic, ex_bne, ex_halt};
  endfunction

  typedef struct {
    logic [22:0] ctl;
    logic [31:0] instr;
    logic [31:0] npc;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  logic [31:0] npc_ctr = 32'h0000_1004;

  always @(negedge CLK) begin
    if (RST) begin
      sb.delete();
    end else if (ex_valid) begin
      if (ex_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_bundle", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_ctl", 64'(ctl_now()), 64'(mon_e.ctl));
          chk("sb_fields", 64'({ex_rs, ex_rt, ex_imm, ex_shamt}),
              64'({mon_e.instr[25:21], mon_e.instr[20:16], mon_e.instr[15:0], mon_e.instr[10:6]}));
          chk("sb_npc", 64'(ex_npc), 64'(mon_e.npc));
        end
      end else if (flush && sb.size() != 0) begin
        void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [22:0] ctl,
                      output int waits, output logic v_acc);
    sb_t e;
    bit  done;
    waits = 0;
    v_acc = 1'b0;
    done  = 1'b0;
    if_valid = 1'b1;
    if_instr = instr;
    if_npc   = npc_ctr;
    while (!done) begin
      @(negedge CLK);
      if (id_ready) begin
        e.ctl = ctl; e.instr = instr; e.npc = npc_ctr;
        sb.push_back(e);
        v_acc = ex_valid;
        done  = 1'b1;
      end else if (waits >= 30) begin
        chk("send_timeout", 64'(waits), 64'd0);
        done = 1'b1;
      end else begin
        @(posedge CLK); #1;
        waits++;
      end
    end
    @(posedge CLK); #1;
    npc_ctr = npc_ctr + 32'd4;
  endtask

  logic [31:0] t_instr[$];
  logic [22:0] t_ctl[$];

  task automatic add_vec(input logic [31:0] instr, input logic [22:0] ctl);
    t_instr.push_back(instr);
    t_ctl.push_back(ctl);
  endtask

  localparam logic [31:0] I_ADDU  = 32'h0022_1821;
  localparam logic [31:0] I_LW    = 32'h8C25_0000;
  localparam logic [31:0] I_ADDU6 = 32'h00A2_3021;
  localparam logic [31:0] I_ORI   = 32'h3427_1234;
  localparam logic [31:0] I_XORI  = 32'h3828_00FF;
  localparam logic [31:0] I_LL    = 32'hC022_0004;
  localparam logic [31:0] I_HALT  = 32'hFFFF_FFFF;

  int   w;
  logic v;

  initial begin
    RST = 1'b1; if_valid = 1'b1; if_instr = I_ADDU; if_npc = 32'd0; ex_ready = 1'b1; flush = 1'b0;
    b_RST = 1'b1; b_if_valid = 1'b0; b_if_instr = 32'd0; b_if_npc = 32'h2000; b_ex_ready = 1'b1;
    b_flush = 1'b0;

    add_vec(32'h0002_5100, mk(0,0,1,1,0,2,10,1,0,0,0,0,0)); // SLL $10,$2,4
    add_vec(32'h0C00_0010, mk(1,0,0,0,2,3,31,1,0,0,0,0,0)); // JAL
    add_vec(32'h03E0_0008, mk(2,0,0,0,2,2,0,0,0,0,0,0,0));  // JR $31
    add_vec(32'h1422_0003, mk(3,1,0,0,3,2,2,0,0,0,0,1,0));  // BNE
    add_vec(32'hAC24_0008, mk(0,1,1,0,2,2,4,0,0,1,0,0,0));  // SW
    add_vec(32'h242B_FFFF, mk(0,1,1,0,2,2,11,1,0,0,0,0,0)); // ADDIU
    add_vec(32'h282C_0005, mk(0,1,1,0,8,2,12,1,0,0,0,0,0)); // SLTI
    add_vec(32'h0022_6823, mk(0,0,0,0,3,2,13,1,0,0,0,0,0)); // SUBU
    add_vec(32'hE022_0000, mk(0,1,1,0,2,1,2,1,0,1,1,0,0));  // SC
    add_vec(32'h3C09_ABCD, mk(0,2,1,0,2,0,9,1,0,0,0,0,0));  // LUI
    add_vec(I_LL,          mk(0,1,1,0,2,1,2,1,1,0,1,0,0));  // LL
    add_vec(32'h0022_0021, mk(0,0,0,0,2,2,0,0,0,0,0,0,0));  // ADDU $0 -> no write

    @(posedge CLK);
    @(negedge CLK);
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_fields", 64'({ctl_now(), ex_rs, ex_rt, ex_imm, ex_shamt}), 64'd0);
    chk("rst_npc", 64'(ex_npc), 64'd0);
    chk("rst_id_ready", 64'(id_ready), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0; b_RST = 1'b0;

    send(I_ADDU, mk(0,0,0,0,2,2,3,1,0,0,0,0,0), w, v);
    chk("first_accept_wait", 64'(w), 64'd0);
    if_valid = 1'b0;
    @(negedge CLK);
    chk("addu_valid", 64'(ex_valid), 64'd1);
    @(posedge CLK); #1;

    // load-use: one bubble, then the dependent instruction issues
    send(I_LW, mk(0,1,1,0,2,1,5,1,1,0,0,0,0), w, v);
    send(I_ADDU6, mk(0,0,0,0,2,2,6,1,0,0,0,0,0), w, v);
    chk("hazard_stall_cycles", 64'(w), 64'd1);
    chk("hazard_bubble", 64'(v), 64'd0);

    for (int i = 0; i < t_instr.size(); i++) send(t_instr[i], t_ctl[i], w, v);

    // backpressure hold
    send(I_ORI, mk(0,0,1,0,5,2,7,1,0,0,0,0,0), w, v);
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = I_XORI; if_npc = npc_ctr;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("hold_id_ready", 64'(id_ready), 64'd0);
      chk("hold_ctl", 64'(ctl_now()), 64'(mk(0,0,1,0,5,2,7,1,0,0,0,0,0)));
      chk("hold_imm", 64'(ex_imm), 64'h1234);
      @(posedge CLK); #1;
    end
    ex_ready = 1'b1;
    send(I_XORI, mk(0,0,1,0,6,2,8,1,0,0,0,0,0), w, v);
    chk("hold_release_wait", 64'(w), 64'd0);

    // illegal opcode and illegal funct
    send(32'hF800_0000, mk(0,0,0,0,2,2,0,0,0,0,0,0,0), w, v);
    if_valid = 1'b0;
    @(negedge CLK);
    chk("ill_op_pulse", 64'(illegal), 64'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("ill_op_pulse_end", 64'(illegal), 64'd0);
    @(posedge CLK); #1;
    send(32'h0022_183F, mk(0,0,0,0,2,2,3,0,0,0,0,0,0), w, v);
    if_valid = 1'b0;
    @(negedge CLK);
    chk("ill_fn_pulse", 64'(illegal), 64'd1);
    @(posedge CLK); #1;

    // flush while EX stalls
    send(I_ORI, mk(0,0,1,0,5,2,7,1,0,0,0,0,0), w, v);
    if_valid = 1'b0; ex_ready = 1'b0; flush = 1'b1;
    @(negedge CLK);
    chk("flush_id_ready", 64'(id_ready), 64'd0);
    @(posedge CLK); #1;
    flush = 1'b0;
    @(negedge CLK);
    chk("flush_valid", 64'(ex_valid), 64'd0);
    ex_ready = 1'b1;
    @(posedge CLK); #1;

    // reset mid-operation discards the held bundle
    send(I_ORI, mk(0,0,1,0,5,2,7,1,0,0,0,0,0), w, v);
    if_valid = 1'b0; ex_ready = 1'b0; RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; ex_ready = 1'b1;
    @(negedge CLK);
    chk("rst_mid_valid", 64'(ex_valid), 64'd0);
    chk("rst_mid_ctl", 64'(ctl_now()), 64'd0);
    @(posedge CLK); #1;

    // HALT is sticky until flush
    send(I_HALT, mk(0,0,0,0,2,2,31,0,0,0,0,0,1), w, v);
    if_valid = 1'b1; if_instr = I_ADDU;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("halt_id_ready", 64'(id_ready), 64'd0);
      chk("halt_sticky", 64'(halted), 64'd1);
      @(posedge CLK); #1;
    end
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0; if_valid = 1'b0;
    @(negedge CLK);
    chk("halt_exit_halted", 64'(halted), 64'd0);
    chk("halt_exit_id_ready", 64'(id_ready), 64'd1);
    @(posedge CLK); #1;
    send(I_ADDU, mk(0,0,0,0,2,2,3,1,0,0,0,0,0), w, v);
    chk("resume_wait", 64'(w), 64'd0);
    if_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // no interlock, no atomics
    b_if_valid = 1'b1; b_if_instr = I_LW;
    @(negedge CLK);
    chk("b_lw_ready", 64'(b_id_ready), 64'd1);
    @(posedge CLK); #1;
    b_if_instr = I_ADDU6;
    @(negedge CLK);
    chk("b_nohaz_ready", 64'(b_id_ready), 64'd1);
    @(posedge CLK); #1;
    b_if_instr = I_LL;
    @(negedge CLK);
    chk("b_addu_wsel", 64'(b_ex_wsel), 64'd6);
    chk("b_addu_valid", 64'(b_ex_valid), 64'd1);
    chk("b_ll_ready", 64'(b_id_ready), 64'd1);
    @(posedge CLK); #1;
    b_if_valid = 1'b0;
    @(negedge CLK);
    chk("b_ll_illegal", 64'(b_illegal), 64'd1);
    chk("b_ll_dren", 64'(b_ex_dREN), 64'd0);
    chk("b_ll_atomic", 64'(b_ex_datomic), 64'd0);
    chk("b_ll_valid", 64'(b_ex_valid), 64'd1);
    @(posedge CLK); #1;

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
